// File: rtl/cube_led_tx.sv
// cube_led_tx: snapshots the blue/white/red sticker planes and shifts the
// 72-bit stream out to an external LED shift-register chain. After the
// stream is sent, it pulses a latch so the chain displays the new frame.
// Stream order: sticker 23 first, and within a sticker red, white, blue.
// sdat is the MSB of the shift register, so it only changes when the
// register shifts at the end of a bit.
module cube_led_tx #(
  parameter int DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] blue,
  input  logic [23:0] white,
  input  logic [23:0] red,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        sclk,
  output logic        sdat,
  output logic        latch
);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DONE} state_t;

  localparam logic [7:0] DIV_LAST = 8'(DIV - 1);
  localparam logic [6:0] BIT_LAST = 7'd71;

  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [6:0]  bit_q, bit_d;
  logic [71:0] shreg_q, shreg_d;
  logic        busy_d, done_d, sclk_d, latch_d;
  logic [71:0] snapshot;

  // Interleave the three planes into the transmit order, sticker 23 at the top
  always_comb begin
    snapshot = '0;
    for (int s = 0; s < 24; s++) begin
      snapshot[3*s+2] = red[s];
      snapshot[3*s+1] = white[s];
      snapshot[3*s]   = blue[s];
    end
  end

  // Next-state, counter and next-output logic; outputs are registered below
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    busy_d  = busy;
    done_d  = 1'b0;
    sclk_d  = sclk;
    latch_d = latch;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        sclk_d  = 1'b0;
        latch_d = 1'b0;
        div_d   = '0;
        bit_d   = '0;
        shreg_d = '0;
        if (start) begin
          state_d = SHIFT;
          shreg_d = snapshot;
          busy_d  = 1'b1;
        end
      end
      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!sclk) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d  = 1'b0;
            shreg_d = {shreg_q[70:0], 1'b0};
            if (bit_q == BIT_LAST) begin
              state_d = LATCH;
              latch_d = 1'b1;
              bit_d   = '0;
            end else begin
              bit_d = bit_q + 7'd1;
            end
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      LATCH: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          state_d = DONE;
          latch_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters, shift register and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sclk    <= 1'b0;
      latch   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      busy    <= busy_d;
      done    <= done_d;
      sclk    <= sclk_d;
      latch   <= latch_d;
    end
  end

  // The register runs empty by the end of the frame, so sdat is 0 in LATCH and IDLE
  assign sdat = shreg_q[71];

endmodule

// File: tb/tb_cube_led_tx.sv
// tb_cube_led_tx: four transmitters (DIV = 1..4) share the same stimulus.
// A frame-level model predicts every output on every cycle from the elapsed
// cycle count since acceptance. Literal checks pin selected cycles.
module tb_cube_led_tx;

  logic        clk;
  logic        rst;
  logic [23:0] blue, white, red;
  logic        start;
  logic [3:0]  busy_w, done_w, sclk_w, sdat_w, latch_w;

  int vectors = 0;
  int miscompares = 0;

  // Model state, per instance
  logic        s_rst, s_start, got_edge;
  logic [71:0] s_snap;
  logic        m_active [4];
  int          m_k [4];
  logic [71:0] m_stream [4];
  int          rises [4];
  logic        prev_sclk [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    cube_led_tx #(.DIV(g + 1)) dut (
      .clk   (clk),
      .rst   (rst),
      .blue  (blue),
      .white (white),
      .red   (red),
      .start (start),
      .busy  (busy_w[g]),
      .done  (done_w[g]),
      .sclk  (sclk_w[g]),
      .sdat  (sdat_w[g]),
      .latch (latch_w[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [71:0] stream_of(input logic [23:0] r, input logic [23:0] w,
                                            input logic [23:0] b);
    logic [71:0] v;
    v = '0;
    for (int s = 23; s >= 0; s--) begin
      v = {v[68:0], r[s], w[s], b[s]};
    end
    return v;
  endfunction

  function automatic logic [4:0] outs(input int i);
    return {busy_w[i], done_w[i], sclk_w[i], sdat_w[i], latch_w[i]};
  endfunction

  // Sample the inputs exactly as the DUT sees them at each rising edge
  always @(posedge clk) begin
    s_rst    <= rst;
    s_start  <= start;
    s_snap   <= stream_of(red, white, blue);
    got_edge <= 1'b1;
  end

  initial begin
    got_edge = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_active[i]  = 1'b0;
      m_k[i]       = 0;
      m_stream[i]  = '0;
      rises[i]     = 0;
      prev_sclk[i] = 1'b0;
    end
  end

  // Advance the frame model one cycle and compare every instance
  always @(negedge clk) begin : compare
    int d, b, ph;
    logic [4:0] e, a;
    logic free;
    if (got_edge) begin
      for (int i = 0; i < 4; i++) begin
        d = i + 1;
        if (s_rst) begin
          m_active[i] = 1'b0;
        end else begin
          free = !m_active[i] || (m_k[i] == 145 * d + 1);
          if (free && s_start) begin
            m_active[i] = 1'b1;
            m_k[i]      = 1;
            m_stream[i] = s_snap;
            rises[i]    = 0;
          end else if (m_active[i]) begin
            m_k[i] = m_k[i] + 1;
            if (m_k[i] > 145 * d + 1) m_active[i] = 1'b0;
          end
        end
        e = 5'b00000;
        if (m_active[i]) begin
          if (m_k[i] <= 144 * d) begin
            b  = (m_k[i] - 1) / (2 * d);
            ph = (m_k[i] - 1) % (2 * d);
            e  = {1'b1, 1'b0, (ph >= d), m_stream[i][71 - b], 1'b0};
          end else if (m_k[i] <= 145 * d) begin
            e = 5'b10001;
          end else begin
            e = 5'b01000;
          end
        end
        a = outs(i);
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("[TB] FAIL cycle_check dut%0d DIV=%0d t=%0t busy/done/sclk/sdat/latch got %b expected %b",
                   i, d, $time, a, e);
        end
        if (!prev_sclk[i] && sclk_w[i] === 1'b1) rises[i]++;
        prev_sclk[i] = sclk_w[i];
        if (e[3]) begin
          vectors++;
          if (rises[i] != 72) begin
            miscompares++;
            $display("[TB] FAIL sclk_rises dut%0d got %0d expected 72", i, rises[i]);
          end
        end
      end
    end
  end

  task automatic apply_stimulus(input logic [23:0] r, input logic [23:0] w,
                                input logic [23:0] b, input logic s);
    red   = r;
    white = w;
    blue  = b;
    start = s;
  endtask

  task automatic check_output(input string name, input logic [4:0] act, input logic [4:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("[TB] FAIL %s busy/done/sclk/sdat/latch got %b expected %b", name, act, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pulse start at the current falling edge and return in cycle T+1
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    apply_stimulus(24'h0, 24'h0, 24'h0, 1'b0);

    // Reset then idle
    tick(3);
    rst = 1'b0;
    tick(20);
    check_output("idle_dut1", outs(1), 5'b00000);
    check_output("idle_dut0", outs(0), 5'b00000);

    // Single-sticker ordering
    apply_stimulus(24'h800000, 24'h0, 24'h000001, 1'b0);
    pulse_start();
    check_output("order_T1", outs(1), 5'b10010);
    tick(3);   check_output("order_T4", outs(1), 5'b10110);
    tick(1);   check_output("order_T5", outs(1), 5'b10000);
    tick(141); check_output("div1_done_T146", outs(0), 5'b01000);
    tick(138); check_output("order_T284", outs(1), 5'b10100);
    tick(1);   check_output("order_T285", outs(1), 5'b10010);
    tick(3);   check_output("order_T288", outs(1), 5'b10110);
    tick(1);   check_output("latch_T289", outs(1), 5'b10001);
    tick(1);   check_output("latch_T290", outs(1), 5'b10001);
    tick(1);   check_output("done_T291", outs(1), 5'b01000);
    tick(1);   check_output("idle_T292", outs(1), 5'b00000);
    tick(300);

    // Snapshot isolation
    apply_stimulus(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 1'b0);
    pulse_start();
    apply_stimulus(24'h0, 24'h0, 24'h0, 1'b0);
    tick(99);
    check_output("snap_dut0_T100", outs(0), 5'b10110);
    check_output("snap_dut3_T100", outs(3), 5'b10010);
    tick(600);

    // Start held high while busy
    start = 1'b1;
    tick(1);
    tick(145); check_output("hold_done_T146", outs(0), 5'b01000);
    tick(1);   check_output("hold_busy_T147", outs(0), 5'b10000);
    tick(145); check_output("hold_done_T292", outs(0), 5'b01000);
    tick(500);
    start = 1'b0;
    tick(600);

    // Reset mid-transfer after the 10th sclk rise of the DIV=3 instance
    apply_stimulus(24'hFFFFFF, 24'h0, 24'h0, 1'b0);
    pulse_start();
    tick(57);
    check_output("abort_T58_rise10", outs(2), 5'b10110);
    rst = 1'b1;
    tick(1);
    check_output("abort_T59_dut2", outs(2), 5'b00000);
    check_output("abort_T59_dut3", outs(3), 5'b00000);
    rst = 1'b0;
    tick(5);
    pulse_start();
    tick(435);
    check_output("abort_refill_done", outs(2), 5'b01000);
    tick(300);

    // Back-to-back frames on the DIV=4 instance
    apply_stimulus(24'h800000, 24'h0, 24'h0, 1'b0);
    pulse_start();
    tick(580);
    check_output("b2b_done_T581", outs(3), 5'b01000);
    pulse_start();
    check_output("b2b_T582", outs(3), 5'b10010);
    tick(3); check_output("b2b_T585", outs(3), 5'b10010);
    tick(1); check_output("b2b_T586", outs(3), 5'b10110);
    tick(600);

    // Randomized planes, start requests and occasional resets
    for (int n = 0; n < 3000; n++) begin
      apply_stimulus(24'($urandom), 24'($urandom), 24'($urandom),
                     ($urandom_range(0, 7) == 0));
      rst = ($urandom_range(0, 999) == 0);
      tick(1);
    end
    rst = 1'b0;
    start = 1'b0;
    tick(600);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
